// File: rtl/fsm_controller.sv
// -----------------------------------------------------------------------------
// fsm_controller
//
// Instruction-sequencing controller for the Simple RISC Machine datapath.
// A start pulse in WAIT latches the decoded opcode/op fields and the
// controller then walks the datapath through a multicycle sequence
// (operand fetch, ALU, writeback) before returning to WAIT.
//
// All outputs are Moore outputs: they depend only on the current state and
// the latched instruction fields, never on the live decoder inputs.
//
// Ports
//   clk      in   1  rising-edge clock, shared with the datapath
//   reset_n  in   1  synchronous, active-low reset
//   s        in   1  start request, only looked at in WAIT
//   opcode   in   3  instruction bits [15:13]
//   op       in   2  instruction bits [12:11]
//   w        out  1  idle/ready, high only in WAIT
//   nsel     out  3  one-hot register select (100 Rn, 010 Rd, 001 Rm)
//   vsel     out  2  writeback source (00 C, 10 sximm8)
//   write    out  1  register-file write enable
//   loada    out  1  A register enable
//   loadb    out  1  B register enable
//   asel     out  1  force A operand to zero
//   bsel     out  1  select sximm5 as B operand
//   ALUop    out  2  ALU operation (00 ADD, 01 SUB, 10 AND, 11 NOT B)
//   loadc    out  1  C register enable
//   loads    out  1  status register enable
// -----------------------------------------------------------------------------
module fsm_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] ALUop,
    output logic       loadc,
    output logic       loads
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // Register-select codes
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    // Writeback source codes
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_opc;
    logic [1:0] r_op;

    logic       w_start;
    logic       w_is_mov_imm;
    logic       w_is_mov_reg;
    logic       w_is_mvn;
    logic       w_is_arith;
    logic       w_is_cmp;

    // Instruction classification from the latched fields only, so decoder
    // activity during a sequence cannot disturb it.
    assign w_start      = (r_state == S_WAIT) && s;
    assign w_is_mov_imm = (r_opc == 3'b110) && (r_op == 2'b10);
    assign w_is_mov_reg = (r_opc == 3'b110) && (r_op == 2'b00);
    assign w_is_mvn     = (r_opc == 3'b101) && (r_op == 2'b11);
    assign w_is_arith   = (r_opc == 3'b101) && (r_op != 2'b11);
    assign w_is_cmp     = (r_opc == 3'b101) && (r_op == 2'b01);

    // -------------------------------------------------------------------------
    // State register and instruction latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_opc   <= 3'b000;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_opc <= opcode;
                r_op  <= op;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WAIT: begin
                if (s) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Unrecognised codes drop straight back to WAIT without
                // touching any register or status enable.
                if (w_is_mov_imm) begin
                    w_next = S_WRITE_IMM;
                end else if (w_is_mov_reg || w_is_mvn) begin
                    w_next = S_GET_B;
                end else if (w_is_arith) begin
                    w_next = S_GET_A;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WRITE_IMM: w_next = S_WAIT;
            S_GET_A:     w_next = S_GET_B;
            S_GET_B:     w_next = S_ALU;
            S_ALU: begin
                // CMP only updates status; it has no writeback cycle.
                if (w_is_cmp) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: w_next = S_WAIT;
            default:     w_next = S_WAIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w     = 1'b0;
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        write = 1'b0;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        ALUop = ALU_ADD;
        loadc = 1'b0;
        loads = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                w = 1'b1;
            end
            S_DECODE: begin
                // Pure decode cycle, nothing enabled.
            end
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                loadc = 1'b1;
                loads = w_is_cmp;
                // MOV Rd,Rm is implemented as 0 + (shifted) B, so the A
                // operand is forced to zero and the ALU is told to add.
                if (w_is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end else begin
                    asel  = 1'b0;
                    ALUop = r_op;
                end
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/fsm_controller.md
# fsm_controller

Instruction-sequencing FSM for the Simple RISC Machine. It sits directly upstream of `datapath` and drives every datapath control input: `vsel`, `write`, `loada`, `loadb`, `asel`, `bsel`, `ALUop`, `loadc` and `loads`. It also drives the register-select code `nsel`, which the instruction decoder turns into `readnum`/`writenum`. On a start pulse it latches the decoded `opcode`/`op` and steps the datapath through a multicycle sequence, then reports idle on `w`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock, shared with `datapath`.
- `reset_n`  in  1  reset; synchronous, active-low.
- `s`  in  1  start; sampled only in WAIT.
- `opcode`  in  3  instruction bits [15:13] from the decoder.
- `op`  in  2  instruction bits [12:11] from the decoder.
- `w`  out  1  idle/ready; 1 only in WAIT.
- `nsel`  out  3  one-hot register select:
  - 100 = Rn
  - 010 = Rd
  - 001 = Rm
  - 000 = none
- `vsel`  out  2  writeback mux select:
  - 00 = C (`datapath_out`)
  - 01 = PC
  - 10 = sximm8
  - 11 = mdata
  - This block drives only 00 and 10.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`  out  1 each  A/B pipeline register enables.
- `asel`, `bsel`  out  1 each  source muxes:
  - `asel`=1 forces A operand to 0.
  - `bsel`=1 selects sximm5.
- `ALUop`  out  2  ALU operation:
  - 00 = ADD
  - 01 = SUB
  - 10 = AND
  - 11 = NOT B
- `loadc`  out  1  C register enable.
- `loads`  out  1  status register enable.

## Operation
- State register states: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- All outputs are Moore: decoded from the state and the latched `opc_q`/`op_q` only.
- Reset (`reset_n`=0 at a rising edge):
  - State becomes WAIT and `opc_q`/`op_q` become 0.
  - Outputs after reset: `w`=1; all other outputs 0 (`nsel`=000, `vsel`=00).
  - Reset applies in any state, including mid-instruction. It aborts the sequence and no further writes occur.
- WAIT:
  - `w`=1; all enables 0.
  - If `s`=1, latch `opcode`→`opc_q` and `op`→`op_q`, then go to DECODE.
  - If `s`=0, stay in WAIT.
- DECODE: no enables asserted. Next state depends on `{opc_q, op_q}`:
  - 110_10 (MOV Rn,#imm8) → WRITE_IMM.
  - 110_00 (MOV Rd,Rm{,sh}) → GET_B.
  - 101_11 (MVN) → GET_B.
  - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) → GET_A.
  - Any other code → WAIT. No register or status change occurs.
- WRITE_IMM: `nsel`=100, `vsel`=10, `write`=1 → WAIT.
- GET_A: `nsel`=100, `loada`=1 → GET_B.
- GET_B: `nsel`=001, `loadb`=1 → ALU.
- ALU: `loadc`=1.
  - MOV Rd,Rm: `asel`=1, `ALUop`=00. Otherwise `asel`=0, `ALUop`=`op_q`.
  - `bsel`=0 always.
  - `loads`=1 only for CMP.
  - Next state: WAIT for CMP, WRITE_REG otherwise.
- WRITE_REG: `nsel`=010, `vsel`=00, `write`=1 → WAIT.
- `s` outside WAIT is ignored. `opcode`/`op` changes outside WAIT are ignored because the latched copies are used.
- `shift` is not driven here; it comes straight from the instruction decoder.

## Timing
- Edge 0 is the rising edge at which WAIT samples `s`=1. Latency counts edges from edge 0 until the state returns to WAIT (`w`=1):
  - MOV imm: 2 edges. The write occurs at edge 2.
  - MOV reg and MVN: 4 edges. The write occurs at edge 4.
  - ADD and AND: 5 edges. The write occurs at edge 5.
  - CMP: 4 edges. The status update occurs at edge 4, with no write.
  - Illegal opcode: 2 edges.
- `w` falls one cycle after `s` is sampled.
- Back-to-back operation: if `s` is held high, a new instruction starts on the first edge back in WAIT.
- At most one of `loada`/`loadb`/`loadc`/`write` is high in any cycle.

## Test plan
- Reset mid-ADD:
  - Stimulus: `reset_n`=0 while in ALU.
  - Response: next cycle WAIT, `w`=1, all enables 0; R2 unchanged.
- MOV R0,#7 then MOV R1,#2 with `datapath` attached:
  - Each takes 2 edges; `w` is high between them.
  - R0=7 and R1=2.
- ADD R2,R1,R0,LSL#1:
  - Enables follow the sequence GET_A `loada` → GET_B `loadb` → ALU `loadc` → WRITE_REG `write`.
  - R2=16 five edges after `s`.
- CMP R0,R0:
  - `loads`=1 only in ALU; no `write` pulse.
  - Z status set; `w` returns after 4 edges.
- MOV R3,R1 and MVN R4,R1:
  - ALU cycle shows `asel`=1, `ALUop`=00 for MOV and `asel`=0, `ALUop`=11 for MVN.
  - R3=2, R4=16'hFFFD.
- Illegal opcode 3'b000 with `s`=1:
  - WAIT→DECODE→WAIT with no enables.
  - `opcode` changes while busy are ignored.
  - `s` held high restarts immediately.
